// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package if_fetch_ctrl_pkg;

    localparam logic        RST_ENABLE      = 1'b1;
    localparam int          INST_ADDR_W     = 32;
    localparam int          INST_W          = 32;
    localparam logic [31:0] PC_RESET_VECTOR = 32'hbfc00000;

    typedef enum logic [1:0] {
        S_REQ     = 2'b00,
        S_WAIT    = 2'b01,
        S_VALID   = 2'b10,
        S_DISCARD = 2'b11
    } fetch_state_e;

    function automatic logic [INST_ADDR_W-1:0] pc_inc(input logic [INST_ADDR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns the PC, one outstanding imem request, branch delay slot and flush.
// Latency: REQ -> WAIT -> VALID, 3 cycles per instruction with addr_ok/data_ok best case.
// Backpressure: stall_i holds the presented instruction and blocks the next request.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = PC_RESET_VECTOR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [INST_ADDR_W-1:0] flush_pc_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_address_i,
    output logic                   inst_req_o,
    output logic [INST_ADDR_W-1:0] inst_addr_o,
    input  logic                   inst_addr_ok_i,
    input  logic                   inst_data_ok_i,
    input  logic [INST_W-1:0]      inst_rdata_i,
    output logic                   if_valid_o,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0]      if_inst_o,
    output logic                   stallreq_o
);

    fetch_state_e           state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic                   br_pend_q, br_pend_d;
    logic [INST_ADDR_W-1:0] br_target_q, br_target_d;
    logic [INST_ADDR_W-1:0] next_pc;
    logic                   consume;
    logic                   capture;

    assign consume = (state_q == S_VALID) && !stall_i;

    // A branch seen in the consume cycle wins over one remembered from earlier.
    always_comb begin
        next_pc = pc_inc(pc_q);
        if (branch_flag_i) begin
            next_pc = branch_target_address_i;
        end else if (br_pend_q) begin
            next_pc = br_target_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        br_pend_d   = br_pend_q;
        br_target_d = br_target_q;
        capture     = 1'b0;

        if (flush_i) begin
            pc_d      = flush_pc_i;
            br_pend_d = 1'b0;
            unique case (state_q)
                S_REQ:     state_d = inst_addr_ok_i ? S_DISCARD : S_REQ;
                S_WAIT:    state_d = inst_data_ok_i ? S_REQ : S_DISCARD;
                S_VALID:   state_d = S_REQ;
                S_DISCARD: state_d = inst_data_ok_i ? S_REQ : S_DISCARD;
                default:   state_d = S_REQ;
            endcase
        end else begin
            // Outside the consume cycle the in-flight instruction is the delay slot.
            if (branch_flag_i && !consume) begin
                br_pend_d   = 1'b1;
                br_target_d = branch_target_address_i;
            end
            unique case (state_q)
                S_REQ: begin
                    if (inst_addr_ok_i) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (inst_data_ok_i) begin
                        capture = 1'b1;
                        state_d = S_VALID;
                    end
                end
                S_VALID: begin
                    if (!stall_i) begin
                        pc_d      = next_pc;
                        br_pend_d = 1'b0;
                        state_d   = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (inst_data_ok_i) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            br_pend_q   <= 1'b0;
            br_target_q <= '0;
            if_pc_o     <= '0;
            if_inst_o   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            br_pend_q   <= br_pend_d;
            br_target_q <= br_target_d;
            if (capture) begin
                if_pc_o   <= pc_q;
                if_inst_o <= inst_rdata_i;
            end
        end
    end

    assign inst_req_o  = (state_q == S_REQ);
    assign inst_addr_o = pc_q;
    assign if_valid_o  = (state_q == S_VALID);
    assign stallreq_o  = ~if_valid_o;

endmodule
